// File: rtl/sr_pkg.sv
// Shared types for the SR flop command sequencer: opcodes, FSM states and queued command payload.
package sr_pkg;

   // Width of the index field carried through the queue; top-level indices are zero-extended into it.
   localparam int unsigned SR_IDX_W = 8;

   typedef enum logic [1:0] {
      SR_NOP    = 2'd0,
      SR_SET    = 2'd1,
      SR_CLR    = 2'd2,
      SR_TOGGLE = 2'd3
   } sr_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRIVE = 3'd1,
      ST_GAP   = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } sr_state_e;

   typedef struct packed {
      sr_op_e                op;
      logic [SR_IDX_W-1:0]   idx;
   } sr_cmd_t;

endpackage

// File: rtl/sr_cmd_fifo.sv
// Synchronous first-word-fall-through command queue with registered occupancy; flushed by reset.
module sr_cmd_fifo
   import sr_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  sr_cmd_t          wdata,
   input  logic             pop,
   output sr_cmd_t          rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   sr_cmd_t          mem_q [DEPTH];
   sr_cmd_t          mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // Next-state: a push into a full queue is refused even if a pop happens in the same cycle.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   // Pointer and occupancy registers; reset empties the queue.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Command-side driver for a bank of SR flops: queues set/clear/toggle commands and issues
// timed, mutually exclusive s/r pulses. Define SR_CMD_READBACK_EN to add a q readback check
// with timeout; without it the sequence ends after the gap and q_fb only steers TOGGLE.
module sr_cmd_sequencer
   import sr_pkg::*;
#(
   parameter  int unsigned WIDTH         = 4,
   parameter  int unsigned FIFO_DEPTH    = 4,
   parameter  int unsigned PULSE_CYC     = 1,
   parameter  int unsigned GAP_CYC       = 1,
   parameter  int unsigned CHECK_TIMEOUT = 4,
   localparam int unsigned IDX_W         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [IDX_W-1:0] cmd_idx,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] r,
   input  logic [WIDTH-1:0] q_fb,
   output logic             done,
   output logic             err,
   output logic [IDX_W-1:0] err_idx,
   input  logic             err_clr
);

   localparam int unsigned CNT_MAX0 = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int unsigned CNT_MAX  = (CNT_MAX0 > CHECK_TIMEOUT) ? CNT_MAX0 : CHECK_TIMEOUT;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
   localparam int unsigned FCNT_W   = $clog2(FIFO_DEPTH) + 1;

   sr_state_e            state_q, state_d;
   logic [SR_IDX_W-1:0]  idx_q, idx_d;
   logic                 set_q, set_d;        // 1: pulse s and expect q=1; 0: pulse r and expect q=0
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     s_q, s_d, r_q, r_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [IDX_W-1:0]     err_idx_q, err_idx_d;
   logic                 cmd_ready_q, cmd_ready_d;

   sr_cmd_t              push_cmd, head;
   logic                 push_c, pop_c;
   logic [FCNT_W-1:0]    fifo_count, fill_next;
   logic                 fifo_full, fifo_empty;
   logic                 head_in_range;
   logic [WIDTH-1:0]     onehot;

   assign cmd_ready = cmd_ready_q;
   assign s         = s_q;
   assign r         = r_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_idx   = err_idx_q;

   assign push_c        = cmd_valid && cmd_ready_q && !fifo_full;
   assign push_cmd.op   = sr_op_e'(cmd_op);
   assign push_cmd.idx  = SR_IDX_W'(cmd_idx);
   assign head_in_range = (head.idx < SR_IDX_W'(WIDTH));
   assign onehot        = WIDTH'(1) << idx_q;

   sr_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_c),
      .wdata (push_cmd),
      .pop   (pop_c),
      .rdata (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state and output decode; s/r/done follow the current state one cycle later.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      set_d     = set_q;
      cnt_d     = cnt_q;
      s_d       = '0;
      r_d       = '0;
      done_d    = 1'b0;
      err_d     = err_q && !err_clr;
      err_idx_d = err_idx_q;
      pop_c     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop_c = 1'b1;
               idx_d = head.idx;
               cnt_d = '0;
               if (!head_in_range) begin
                  state_d   = ST_DONE;
                  err_d     = 1'b1;
                  err_idx_d = IDX_W'(head.idx);
               end else begin
                  case (head.op)
                     SR_SET:    begin set_d = 1'b1;                      state_d = ST_DRIVE; end
                     SR_CLR:    begin set_d = 1'b0;                      state_d = ST_DRIVE; end
                     SR_TOGGLE: begin set_d = !q_fb[IDX_W'(head.idx)];  state_d = ST_DRIVE; end
                     default:   state_d = ST_DONE;
                  endcase
               end
            end
         end
         ST_DRIVE: begin
            s_d = set_q ? onehot : '0;
            r_d = set_q ? '0 : onehot;
            if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
               cnt_d   = '0;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
               cnt_d = '0;
`ifdef SR_CMD_READBACK_EN
               state_d = ST_CHECK;
`else
               state_d = ST_DONE;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef SR_CMD_READBACK_EN
         ST_CHECK: begin
            if (q_fb[IDX_W'(idx_q)] == set_q) begin
               state_d = ST_DONE;
            end else if (cnt_q == CNT_W'(CHECK_TIMEOUT - 1)) begin
               state_d   = ST_DONE;
               err_d     = 1'b1;
               err_idx_d = IDX_W'(idx_q);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Ready tracks the occupancy after this edge, so a pop from full frees a slot one cycle later.
      fill_next   = fifo_count + FCNT_W'(push_c) - FCNT_W'(pop_c);
      cmd_ready_d = (fill_next != FCNT_W'(FIFO_DEPTH));
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         set_q       <= 1'b0;
         cnt_q       <= '0;
         s_q         <= '0;
         r_q         <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_idx_q   <= '0;
         cmd_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         set_q       <= set_d;
         cnt_q       <= cnt_d;
         s_q         <= s_d;
         r_q         <= r_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_idx_q   <= err_idx_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

endmodule

// File: doc/sr_cmd_sequencer.md
Name: sr_cmd_sequencer

Overview:
- Command-side driver for a bank of WIDTH sr_ff instances; it is the initiator that produces the s/r inputs those flops consume.
- Accepts set, clear and toggle commands over a valid/ready interface and buffers them in a small FIFO.
- Drives timed, mutually exclusive s/r pulses, so s=r=1 is never presented to any flop.
- Optionally reads back q to confirm each command took effect.

Parameters:
- WIDTH, 4, number of SR flops driven.
- FIFO_DEPTH, 4, command queue entries (power of 2, at least 2).
- PULSE_CYC, 1, cycles s or r is held high per command (at least 1).
- GAP_CYC, 1, all-low cycles after each pulse (at least 1).
- CHECK_TIMEOUT, 4, maximum cycles waiting for readback match (at least 1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  queue can accept.
- cmd_op  in  2  0=NOP, 1=SET, 2=CLR, 3=TOGGLE.
- cmd_idx  in  $clog2(WIDTH)  target flop index.
- s  out  WIDTH  set lines to the flops.
- r  out  WIDTH  reset lines to the flops.
- q_fb  in  WIDTH  q readback from the flops.
- done  out  1  one-cycle pulse per completed command.
- err  out  1  sticky error flag.
- err_idx  out  $clog2(WIDTH)  index of the most recent error.
- err_clr  in  1  clears err.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high, ports named clk and reset.
- Reset:
  - s=0, r=0, done=0, err=0, err_idx=0.
  - FIFO emptied, FSM in IDLE, cmd_ready=0 while reset is high.
  - cmd_ready=1 from the first cycle after reset falls.
- Reset mid-operation: at the next edge s/r drop to 0, the in-flight command is discarded and the FIFO is flushed. No done pulse for flushed commands.
- Handshake:
  - A push occurs when cmd_valid && cmd_ready.
  - cmd_ready = !full, computed from the registered count.
  - A pop in the same cycle does not make a full FIFO ready; it becomes ready the next cycle.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop and latch op/idx.
    - idx >= WIDTH: go to DONE with err set.
    - NOP: go to DONE.
    - SET: expect 1, drive s.
    - CLR: expect 0, drive r.
    - TOGGLE: sample q_fb[idx] at the pop edge; drive r if it is 1, otherwise s; expect the inverse.
    - Non-NOP commands go to DRIVE.
  - DRIVE: registered s[idx] or r[idx] high for exactly PULSE_CYC cycles, all other bits 0; then GAP.
  - GAP: s=r=0 for GAP_CYC cycles; then CHECK when the readback feature is compiled in, otherwise DONE.
  - CHECK: compare q_fb[idx] with the expected value every cycle.
    - Match: go to DONE.
    - No match after CHECK_TIMEOUT cycles: set err, err_idx=idx, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: for a command accepted at edge N into an empty FIFO with the FSM in IDLE:
  - The pop happens at edge N+1.
  - s/r is high from edge N+2 through edge N+2+PULSE_CYC.
  - Back-to-back commands are separated by at least GAP_CYC+1 low cycles.
- Invariant: (s & r) == 0 in every cycle, and at most one bit of s|r is high.
- err_clr: clears err at the next edge. If err_clr and a new error occur in the same cycle, set wins. err_idx is never cleared except by reset.
- Full FIFO: pushes are refused, with no loss and no overwrite. Empty FIFO: FSM stays in IDLE, outputs 0.

Optional Feature:
- Macro: SR_CMD_READBACK_EN.
- When defined: the CHECK state exists, q_fb is compared, and timeouts set err.
- When undefined:
  - CHECK is removed and GAP goes directly to DONE.
  - q_fb is unused except for the TOGGLE decision.
  - err is set only for out-of-range idx.

Decomposition:
- Package sr_pkg:
  - sr_op_e enum (NOP, SET, CLR, TOGGLE).
  - sr_state_e enum (IDLE, DRIVE, GAP, CHECK, DONE).
  - sr_cmd_t struct {op, idx}.
- Sub-module sr_cmd_fifo: synchronous FIFO of sr_cmd_t with registered count, full and empty. It flushes on reset.
- The FSM and pulse/gap/timeout counter stay in sr_cmd_sequencer.

Test Plan:
- Bench configuration: WIDTH=4, PULSE_CYC=2, GAP_CYC=1, CHECK_TIMEOUT=4, four real sr_ff instances in the feedback loop.
- Reset, then SET idx=2 → s=4'b0100 for exactly 2 cycles starting 2 edges after accept; q[2]=1; one done pulse; err=0.
- SET idx=1 then TOGGLE idx=1 back-to-back → s[1] pulse, at least 2 low cycles, r[1] pulse; q[1] ends at 0; two done pulses; (s&r)==0 throughout.
- Push 6 commands continuously with the FSM busy → cmd_ready falls after 4 accepted (plus any popped); no command lost; done count equals accepted count.
- Readback timeout: force q_fb[3]=0, then SET idx=3 → err=1 and err_idx=3 after 4 CHECK cycles; assert err_clr → err=0. Repeat with error and err_clr in the same cycle → err stays 1.
- Reset asserted during DRIVE of CLR idx=0 with 2 commands queued → s=r=0 next edge; no done pulses; FIFO empty; cmd_ready=1 one cycle after reset falls.
- Build with SR_CMD_READBACK_EN undefined → no CHECK state; done arrives GAP_CYC+1 cycles after the pulse ends; forced-wrong q_fb produces no err.
